// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES helpers: field constants, byte indexing, GF(2^8) multiplies
package aes_pkg;

  // Low byte of the AES field polynomial x^8+x^4+x^3+x+1
  localparam logic [7:0] AES_POLY = 8'h1B;

  typedef logic [127:0] state_t;

  // Multiply by x in GF(2^8), reducing by the field polynomial on overflow
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
  endfunction

  // Multiply by x+1 in GF(2^8)
  function automatic logic [7:0] gmul3(input logic [7:0] x);
    return xtime(x) ^ x;
  endfunction

  // Byte position of matrix element (row r, column c) in a flat 128-bit state
  function automatic int idx(input int r, input int c);
    return r + 4 * c;
  endfunction

endpackage

// File: rtl/aes_mix_column.sv
// rtl/aes_mix_column.sv - combinational MixColumns transform of one 32-bit column
module aes_mix_column
  import aes_pkg::*;
(
  input  logic [31:0] col,
  output logic [31:0] mixed
);

  logic [7:0] a0, a1, a2, a3;

  assign a0 = col[7:0];
  assign a1 = col[15:8];
  assign a2 = col[23:16];
  assign a3 = col[31:24];

  // Fixed circulant matrix {2,3,1,1} applied to the column; row 0 is the low byte
  always_comb begin
    mixed          = '0;
    mixed[7:0]     = xtime(a0) ^ gmul3(a1) ^ a2 ^ a3;
    mixed[15:8]    = a0 ^ xtime(a1) ^ gmul3(a2) ^ a3;
    mixed[23:16]   = a0 ^ a1 ^ xtime(a2) ^ gmul3(a3);
    mixed[31:24]   = gmul3(a0) ^ a1 ^ a2 ^ xtime(a3);
  end

endmodule

// File: rtl/aes_shift_mix_ark.sv
// rtl/aes_shift_mix_ark.sv - AES round tail: ShiftRows, MixColumns, AddRoundKey in a 2-stage pipeline
module aes_shift_mix_ark
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic [127:0] in_key,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         out_last
);

  state_t shifted;
  state_t mixed;
  state_t s1_next;

  logic   s1_valid;
  state_t s1_state;
  state_t s1_key;
  logic   s1_last;

  logic   s2_adv;
  logic   s1_load;

  // ShiftRows is pure wiring: row r of column c takes the byte from column (c+r) mod 4
  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < 4; c++) begin : g_col
      localparam int DST = idx(r, c);
      localparam int SRC = idx(r, (c + r) % 4);
      assign shifted[8*DST +: 8] = in_state[8*SRC +: 8];
    end
  end

  for (genvar c = 0; c < 4; c++) begin : g_mix
    aes_mix_column u_mix (
      .col   (shifted[32*c +: 32]),
      .mixed (mixed[32*c +: 32])
    );
  end

  // The final round skips MixColumns
  assign s1_next = in_last ? shifted : mixed;

  // Output register frees up when empty or being drained; stage 1 frees up when it can hand off
  assign s2_adv   = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_adv;
  assign s1_load  = in_valid && in_ready;

  // Stage 1: capture the transformed state with its key; go empty on handoff without a new load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_state <= '0;
      s1_key   <= '0;
      s1_last  <= 1'b0;
    end else if (s1_load) begin
      s1_valid <= 1'b1;
      s1_state <= s1_next;
      s1_key   <= in_key;
      s1_last  <= in_last;
    end else if (s2_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2: AddRoundKey into the output register; holds bit-stable while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_state <= '0;
      out_last  <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      out_state <= s1_state ^ s1_key;
      out_last  <= s1_last;
    end
  end

endmodule

// File: tb/tb_aes_shift_mix_ark.sv
// tb/tb_aes_shift_mix_ark.sv - self-checking bench for aes_shift_mix_ark
module tb_aes_shift_mix_ark;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_state = '0;
  logic [127:0] in_key = '0;
  logic         in_last = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_state;
  logic         out_last;

  aes_shift_mix_ark dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .in_key    (in_key),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] st;
    logic         last;
    int           acc;
  } exp_t;

  exp_t         sb[$];
  int           n_vec = 0;
  int           n_err = 0;
  int           cyc = 0;
  bit           chk_lat = 1'b0;
  bit           use_lit = 1'b0;
  bit           accepted = 1'b0;
  logic [127:0] lit_state = '0;
  logic [127:0] hold_state;
  logic         hold_last;
  int           nacc;
  int           budget;

  // Generic GF(2^8) multiply by shift-and-add with reduction
  function automatic logic [7:0] gmul(input logic [7:0] a, input int b);
    logic [7:0] p;
    logic [7:0] x;
    logic       hi;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (((b >> i) & 1) == 1) p = p ^ x;
      hi = x[7];
      x = x << 1;
      if (hi) x = x ^ 8'h1B;
    end
    return p;
  endfunction

  // Reference round tail on a 4x4 byte matrix
  function automatic logic [127:0] model(input logic [127:0] st, input logic [127:0] key,
                                         input logic last);
    logic [7:0]   s [4][4];
    logic [7:0]   sh[4][4];
    logic [7:0]   m [4][4];
    int           coef[4];
    logic [127:0] res;
    coef = '{2, 3, 1, 1};
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        s[r][c] = st[8*(r+4*c) +: 8];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        sh[r][c] = s[r][(c+r)%4];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        if (last) m[r][c] = sh[r][c];
        else begin
          m[r][c] = 8'h00;
          for (int k = 0; k < 4; k++)
            m[r][c] = m[r][c] ^ gmul(sh[k][c], coef[(k-r+4)%4]);
        end
      end
    res = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        res[8*(r+4*c) +: 8] = m[r][c];
    return res ^ key;
  endfunction

  task automatic check(input string tag, input logic [128:0] obs, input logic [128:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: sample handshakes before the edge, score them, then step past the edge
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $error("FAIL spurious_out observed=%h expected=none", out_state);
      end else begin
        e = sb.pop_front();
        check("out_data", {out_last, out_state}, {e.last, e.st});
        if (chk_lat) check("latency", 129'(cyc + 1 - e.acc), 129'd2);
      end
    end
    accepted = in_valid && in_ready;
    if (accepted) begin
      e.st   = use_lit ? lit_state : model(in_state, in_key, in_last);
      e.last = in_last;
      e.acc  = cyc + 1;
      sb.push_back(e);
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic new_vec(input bit rand_last);
    in_state = {$urandom, $urandom, $urandom, $urandom};
    in_key   = {$urandom, $urandom, $urandom, $urandom};
    in_last  = rand_last ? 1'($urandom_range(0, 1)) : 1'b0;
  endtask

  task automatic send_lit(input logic [127:0] st, input logic [127:0] key, input logic last,
                          input logic [127:0] exp, input string tag);
    in_state  = st;
    in_key    = key;
    in_last   = last;
    lit_state = exp;
    use_lit   = 1'b1;
    in_valid  = 1'b1;
    tick();
    check(tag, 129'(accepted), 129'd1);
    in_valid = 1'b0;
    use_lit  = 1'b0;
    tick();
    tick();
    check({tag, "_drained"}, 129'(sb.size()), 129'd0);
  endtask

  task automatic drain();
    budget = 0;
    while (sb.size() != 0 && budget < 40) begin
      tick();
      budget++;
    end
    check("drain", 129'(sb.size()), 129'd0);
  endtask

  initial begin
    // Reset state
    #1;
    check("rst_in_ready", 129'(in_ready), 129'd1);
    check("rst_out", {out_last, out_state}, 129'd0);
    check("rst_out_valid", 129'(out_valid), 129'd0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Directed vectors with no backpressure
    out_ready = 1'b1;
    chk_lat   = 1'b1;
    send_lit(128'h0, 128'h000102030405060708090a0b0c0d0e0f, 1'b0,
             128'h000102030405060708090a0b0c0d0e0f, "zero_state_key");
    send_lit({4{32'h455313db}}, 128'h0, 1'b0, {4{32'hbca14d8e}}, "mixcol_fips");
    send_lit(128'h0f0e0d0c0b0a09080706050403020100, 128'h0, 1'b1,
             128'h0b06010c07020d08030e09040f0a0500, "shiftrows_last");

    // Back-to-back stream of 8
    for (int i = 0; i < 8; i++) begin
      new_vec(1'b1);
      in_valid = 1'b1;
      tick();
      check("stream_accept", 129'(accepted), 129'd1);
    end
    in_valid = 1'b0;
    drain();

    // Stall for 5 cycles while streaming
    chk_lat   = 1'b0;
    out_ready = 1'b0;
    nacc      = 0;
    new_vec(1'b1);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (accepted) begin
        nacc++;
        new_vec(1'b1);
      end
      if (i == 1) begin
        hold_state = out_state;
        hold_last  = out_last;
      end else if (i > 1) begin
        check("stall_stable", {out_last, out_state}, {hold_last, hold_state});
      end
    end
    check("stall_accepts", 129'(nacc), 129'd2);
    check("stall_in_ready", 129'(in_ready), 129'd0);
    check("stall_out_valid", 129'(out_valid), 129'd1);
    out_ready = 1'b1;
    budget    = 0;
    while (nacc < 6 && budget < 40) begin
      tick();
      budget++;
      if (accepted) begin
        nacc++;
        new_vec(1'b1);
      end
    end
    in_valid = 1'b0;
    check("stall_resume", 129'(nacc), 129'd6);
    drain();

    // Random valid/ready traffic
    for (int i = 0; i < 150; i++) begin
      if (!in_valid || accepted) begin
        in_valid = ($urandom_range(0, 3) != 0);
        new_vec(1'b1);
      end
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();

    // Asynchronous reset with both stages full
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      new_vec(1'b1);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    check("full_in_ready", 129'(in_ready), 129'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_out_valid", 129'(out_valid), 129'd0);
    check("async_out", {out_last, out_state}, 129'd0);
    check("async_in_ready", 129'(in_ready), 129'd1);
    sb.delete();
    @(posedge clk);
    #3;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    chk_lat   = 1'b1;
    new_vec(1'b1);
    in_valid = 1'b1;
    check("post_rst_in_ready", 129'(in_ready), 129'd1);
    tick();
    check("post_rst_accept", 129'(accepted), 129'd1);
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    check("post_rst_drained", 129'(sb.size()), 129'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
